// File: rtl/ram_arbiter.sv
// Two-port req/ack arbiter in front of a single-port RAM. One access per grant,
// all RAM controls registered, read data returned with a one-cycle ack pulse.
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RR     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              ram_wen,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  state_t state_reg, state_next;
  logic   gnt_reg;
  logic   last_reg;
  logic   any_req;
  logic   win;
  logic   win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Winner is only meaningful in IDLE with at least one request pending.
  always_comb begin
    any_req = p0_req | p1_req;
    win     = p1_req;
    if (p0_req && p1_req)
      win = (RR != 0) ? ~last_reg : 1'b1;
    win_we    = win ? p1_we    : p0_we;
    win_addr  = win ? p1_addr  : p0_addr;
    win_wdata = win ? p1_wdata : p0_wdata;

    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= 1'b0;
      last_reg  <= 1'b1;
      ram_wen   <= 1'b0;
      ram_ren   <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            gnt_reg  <= win;
            last_reg <= win;
            ram_wen  <= win_we;
            ram_ren  <= ~win_we;
            ram_addr <= win_addr;
            ram_din  <= win_wdata;
          end
        end
        ACCESS: begin
          // The RAM read data is valid now because the controls were registered.
          if (ram_ren) begin
            if (gnt_reg) p1_rdata <= ram_dout;
            else         p0_rdata <= ram_dout;
          end
          ram_wen <= 1'b0;
          ram_ren <= 1'b0;
          if (gnt_reg) p1_ack <= 1'b1;
          else         p0_ack <= 1'b1;
        end
        DONE: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one round-robin and one fixed-priority instance
// share the same requester stimulus, each with its own 64Kx16 RAM model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  logic        a_p0_ack, a_p1_ack, a_ram_wen, a_ram_ren, a_busy;
  logic [15:0] a_p0_rdata, a_p1_rdata, a_ram_addr, a_ram_din, a_ram_dout;
  logic        b_p0_ack, b_p1_ack, b_ram_wen, b_ram_ren, b_busy;
  logic [15:0] b_p0_rdata, b_p1_rdata, b_ram_addr, b_ram_din, b_ram_dout;

  logic [15:0] mem_a [0:65535] = '{default: 16'h0000};
  logic [15:0] mem_b [0:65535] = '{default: 16'h0000};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .RR(1)) u_rr (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
    .ram_wen(a_ram_wen), .ram_ren(a_ram_ren), .ram_addr(a_ram_addr),
    .ram_din(a_ram_din), .ram_dout(a_ram_dout), .busy(a_busy)
  );

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .RR(0)) u_fp (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .ram_wen(b_ram_wen), .ram_ren(b_ram_ren), .ram_addr(b_ram_addr),
    .ram_din(b_ram_din), .ram_dout(b_ram_dout), .busy(b_busy)
  );

  assign a_ram_dout = mem_a[a_ram_addr];
  assign b_ram_dout = mem_b[b_ram_addr];

  always @(posedge clk) begin
    if (a_ram_wen) mem_a[a_ram_addr] <= a_ram_din;
    if (b_ram_wen) mem_b[b_ram_addr] <= b_ram_din;
  end

  // Exclusivity of RAM enables and acks, checked every cycle throughout.
  always @(negedge clk) begin
    total++;
    if ((a_ram_wen && a_ram_ren) || (b_ram_wen && b_ram_ren)) begin
      bad++;
      $display("FAIL excl_en: rr wen/ren=%b%b fp wen/ren=%b%b, required not both 1",
               a_ram_wen, a_ram_ren, b_ram_wen, b_ram_ren);
    end
    total++;
    if ((a_p0_ack && a_p1_ack) || (b_p0_ack && b_p1_ack)) begin
      bad++;
      $display("FAIL excl_ack: rr acks=%b%b fp acks=%b%b, required not both 1",
               a_p0_ack, a_p1_ack, b_p0_ack, b_p1_ack);
    end
  end

  // Single request on one port, waiting on the round-robin instance's ack.
  // lat counts falling edges after req rises; ack is expected on the third.
  task automatic txn(input bit p, input logic we, input logic [15:0] addr,
                     input logic [15:0] wd, output logic [15:0] rd, output int lat);
    lat = 0;
    @(posedge clk); #1;
    if (!p) begin p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd; end
    else    begin p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd; end
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (p ? a_p1_ack : a_p0_ack) break;
    end
    rd = p ? a_p1_rdata : a_p0_rdata;
    p0_req = 1'b0;
    p1_req = 1'b0;
    $display("txn port=%0d we=%0b addr=%h wdata=%h rdata=%h lat=%0d", p, we, addr, wd, rd, lat);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((a_busy || b_busy) && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (a_busy || b_busy) begin
      bad++;
      $display("FAIL idle_timeout: busy rr=%b fp=%b, required 0", a_busy, b_busy);
    end
  endtask

  task automatic test_reset_initial();
    #1;
    total++;
    if ({a_p0_ack, a_p1_ack, a_ram_wen, a_ram_ren, a_busy, a_ram_addr, a_ram_din,
         a_p0_rdata, a_p1_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_rr: outputs nonzero ack=%b%b wen=%b ren=%b busy=%b, required all 0",
               a_p0_ack, a_p1_ack, a_ram_wen, a_ram_ren, a_busy);
    end
    total++;
    if ({b_p0_ack, b_p1_ack, b_ram_wen, b_ram_ren, b_busy, b_ram_addr, b_ram_din,
         b_p0_rdata, b_p1_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_fp: outputs nonzero ack=%b%b wen=%b ren=%b busy=%b, required all 0",
               b_p0_ack, b_p1_ack, b_ram_wen, b_ram_ren, b_busy);
    end
    $display("reset released");
  endtask

  task automatic test_write_read();
    logic [15:0] rd;
    int lat;
    txn(1'b1, 1'b1, 16'h0010, 16'hBEEF, rd, lat);
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL wr_latency: got %0d, required 3", lat);
    end
    total++;
    if (a_p1_rdata !== 16'h0000) begin
      bad++; $display("FAIL wr_rdata_hold: p1_rdata=%h, required 0000", a_p1_rdata);
    end
    txn(1'b0, 1'b0, 16'h0010, 16'h0000, rd, lat);
    total++;
    if (rd !== 16'hBEEF || lat !== 3) begin
      bad++; $display("FAIL rd_after_wr: rdata=%h lat=%0d, required BEEF lat 3", rd, lat);
    end
    total++;
    if (a_p1_rdata !== 16'h0000 || b_p0_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL rdata_ports: rr p1_rdata=%h fp p0_rdata=%h, required 0000 BEEF",
               a_p1_rdata, b_p0_rdata);
    end
    // Preload 0x0011 for the contention tests.
    txn(1'b1, 1'b1, 16'h0011, 16'h5555, rd, lat);
    total++;
    if (lat !== 3) begin
      bad++; $display("FAIL wr2_latency: got %0d, required 3", lat);
    end
  endtask

  task automatic test_reset_midrun();
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0011; p0_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    total++;
    if (a_p0_ack !== 1'b1 || a_p0_rdata !== 16'h5555) begin
      bad++;
      $display("FAIL pre_reset_read: ack=%b rdata=%h, required 1 5555", a_p0_ack, a_p0_rdata);
    end
    #2 rst = 1'b1;
    #1;
    p0_req = 1'b0;
    total++;
    if ({a_p0_ack, a_p1_ack, a_ram_wen, a_ram_ren, a_busy, a_p0_rdata, a_p1_rdata,
         b_p0_ack, b_p1_ack, b_ram_wen, b_ram_ren, b_busy, b_p0_rdata, b_p1_rdata} !== '0) begin
      bad++;
      $display("FAIL midrun_reset: rr ack=%b%b busy=%b p0_rdata=%h fp busy=%b p0_rdata=%h, required all 0",
               a_p0_ack, a_p1_ack, a_busy, a_p0_rdata, b_busy, b_p0_rdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("midrun reset done");
  endtask

  task automatic test_round_robin();
    int k = 0;
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0011;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (a_p0_ack || a_p1_ack) begin
        total++;
        if (a_p1_ack !== k[0] || n != 3 * (k + 1) ||
            (k[0] ? a_p1_rdata : a_p0_rdata) !== (k[0] ? 16'h5555 : 16'hBEEF)) begin
          bad++;
          $display("FAIL rr_grant%0d: port=%0d cycle=%0d rdata=%h, required port=%0d cycle=%0d",
                   k, a_p1_ack, n, k[0] ? a_p1_rdata : a_p0_rdata, k[0], 3 * (k + 1));
        end
        $display("rr ack %0d port=%0d cycle=%0d", k, a_p1_ack, n);
        k++;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    total++;
    if (k != 4) begin
      bad++; $display("FAIL rr_count: got %0d acks, required 4", k);
    end
    wait_idle();
  endtask

  task automatic test_fixed_priority();
    int p1_cnt = 0;
    int p0_first = 0;
    @(posedge clk); #1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0011;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (b_p1_ack) begin
        p1_cnt++;
        total++;
        if (n % 3 != 0 || b_p1_rdata !== 16'h5555) begin
          bad++;
          $display("FAIL fp_p1_ack: cycle=%0d rdata=%h, required multiple of 3 and 5555", n, b_p1_rdata);
        end
        $display("fp ack port=1 cycle=%0d", n);
      end
      if (b_p0_ack && p0_first == 0) begin
        p0_first = n;
        total++;
        if (b_p0_rdata !== 16'hBEEF) begin
          bad++; $display("FAIL fp_p0_rdata: got %h, required BEEF", b_p0_rdata);
        end
        $display("fp ack port=0 cycle=%0d", n);
      end
      if (n == 9) p1_req = 1'b0;
    end
    p0_req = 1'b0;
    total++;
    if (p1_cnt != 3 || p0_first != 12) begin
      bad++;
      $display("FAIL fp_order: p1 acks=%0d p0 first cycle=%0d, required 3 and 12", p1_cnt, p0_first);
    end
    wait_idle();
  endtask

  task automatic test_top_address();
    logic [15:0] rd;
    int lat;
    txn(1'b0, 1'b1, 16'hFFFF, 16'h1234, rd, lat);
    txn(1'b1, 1'b0, 16'hFFFF, 16'h0000, rd, lat);
    total++;
    if (rd !== 16'h1234 || lat !== 3) begin
      bad++; $display("FAIL top_read: rdata=%h lat=%0d, required 1234 lat 3", rd, lat);
    end
    txn(1'b1, 1'b0, 16'h0000, 16'h0000, rd, lat);
    total++;
    if (rd !== 16'h0000) begin
      bad++; $display("FAIL addr0_alias: rdata=%h, required 0000", rd);
    end
  endtask

  task automatic test_reset_access();
    logic [15:0] rd;
    int lat;
    @(posedge clk); #1;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h0020; p1_wdata = 16'hAAAA;
    @(posedge clk); #2;
    total++;
    if (a_ram_wen !== 1'b1 || a_ram_addr !== 16'h0020 || a_ram_din !== 16'hAAAA || a_busy !== 1'b1) begin
      bad++;
      $display("FAIL access_ctrl: wen=%b addr=%h din=%h busy=%b, required 1 0020 AAAA 1",
               a_ram_wen, a_ram_addr, a_ram_din, a_busy);
    end
    rst = 1'b1;
    #1;
    p1_req = 1'b0;
    total++;
    if (a_ram_wen !== 1'b0 || a_busy !== 1'b0 || b_ram_wen !== 1'b0) begin
      bad++;
      $display("FAIL abort_wen: rr wen=%b busy=%b fp wen=%b, required 0 0 0", a_ram_wen, a_busy, b_ram_wen);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++;
      if (a_p1_ack || b_p1_ack) begin
        bad++; $display("FAIL abort_ack: rr=%b fp=%b, required 0", a_p1_ack, b_p1_ack);
      end
    end
    rst = 1'b0;
    txn(1'b1, 1'b0, 16'h0020, 16'h0000, rd, lat);
    total++;
    if (rd !== 16'h0000 || lat !== 3) begin
      bad++; $display("FAIL abort_commit: rdata=%h lat=%0d, required 0000 lat 3", rd, lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    repeat (2) @(posedge clk);
    test_reset_initial();
    @(negedge clk);
    rst = 1'b0;
    test_write_read();
    test_reset_midrun();
    test_round_robin();
    test_fixed_priority();
    test_top_address();
    test_reset_access();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
